// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 receiver and its driver: register
// addresses, frame geometry and the receiver FSM state encoding.
package max7219_pkg;

   localparam int FRAME_W = 16;
   localparam int CNT_W   = $clog2(FRAME_W + 1);

   localparam logic [3:0] NOOP         = 4'h0;
   localparam logic [3:0] DIGIT0       = 4'h1;
   localparam logic [3:0] DIGIT1       = 4'h2;
   localparam logic [3:0] DIGIT2       = 4'h3;
   localparam logic [3:0] DIGIT3       = 4'h4;
   localparam logic [3:0] DIGIT4       = 4'h5;
   localparam logic [3:0] DIGIT5       = 4'h6;
   localparam logic [3:0] DIGIT6       = 4'h7;
   localparam logic [3:0] DIGIT7       = 4'h8;
   localparam logic [3:0] DECODE_MODE  = 4'h9;
   localparam logic [3:0] INTENSITY    = 4'hA;
   localparam logic [3:0] SCAN_LIMIT   = 4'hB;
   localparam logic [3:0] SHUTDOWN     = 4'hC;
   localparam logic [3:0] DISPLAY_TEST = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_LATCH
   } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchroniser for one SPI pin, with a history flop so that
// rising and falling edges can be detected in the clk domain.
module spi_pin_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] r_sync;
   logic              r_hist;

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: resetting to 0 means a cs already low at reset release is not seen as a fall.
      if (rst) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         // NOTE: non-blocking updates make every stage sample its neighbour's old value.
         r_sync <= {r_sync[STAGES-2:0], d};
         r_hist <= r_sync[STAGES-1];
      end
   end

   assign q    = r_sync[STAGES-1];
   assign rise = q & ~r_hist;
   assign fall = ~q & r_hist;

endmodule

// File: rtl/max7219_receiver.sv
// MAX7219 SPI slave model: oversamples sck/mosi/cs in the clk domain, shifts
// 16-bit frames, keeps the chip register file and provides the delayed dout.
module max7219_receiver
   import max7219_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sck,
   input  logic        mosi,
   input  logic        cs,
   output logic        dout,
   output logic [63:0] pixels,
   output logic [7:0]  decode_mode,
   output logic [3:0]  intensity,
   output logic [2:0]  scan_limit,
   output logic        shutdown_n,
   output logic        display_test,
   output logic        frame_valid,
   output logic [3:0]  frame_addr,
   output logic [7:0]  frame_data,
   output logic        frame_error
);

   logic w_sck_q,  w_sck_rise,  w_sck_fall;
   logic w_mosi_q, w_mosi_rise, w_mosi_fall;
   logic w_cs_q,   w_cs_rise,   w_cs_fall;
   logic w_unused;

   spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
      .clk(clk), .rst(rst), .d(sck), .q(w_sck_q), .rise(w_sck_rise), .fall(w_sck_fall)
   );
   spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(clk), .rst(rst), .d(mosi), .q(w_mosi_q), .rise(w_mosi_rise), .fall(w_mosi_fall)
   );
   spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
      .clk(clk), .rst(rst), .d(cs), .q(w_cs_q), .rise(w_cs_rise), .fall(w_cs_fall)
   );

   assign w_unused = ^{w_sck_q, w_mosi_rise, w_mosi_fall, w_cs_q};

   state_t             r_state, w_next;
   logic               w_shift, w_clear, w_commit;
   logic [FRAME_W-1:0] r_sr;
   logic [CNT_W-1:0]   r_count;
   logic               w_full;
   logic               r_dout;
   logic [3:0]         w_addr;
   logic [7:0]         w_data;
   logic [2:0]         w_digit_idx;

   assign w_full      = (r_count == CNT_W'(FRAME_W));
   assign w_addr      = r_sr[11:8];
   assign w_data      = r_sr[7:0];
   assign w_digit_idx = 3'(w_addr - DIGIT0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      // NOTE: every signal gets a default first so no latch is inferred.
      w_next   = r_state;
      w_shift  = 1'b0;
      w_clear  = 1'b0;
      w_commit = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_cs_fall) begin
               w_next  = ST_SHIFT;
               w_clear = 1'b1;
               w_shift = w_sck_rise;
            end
         end
         ST_SHIFT: begin
            // A sck edge coinciding with the cs rise is discarded.
            if (w_cs_rise) begin
               w_next   = ST_LATCH;
               w_commit = 1'b1;
            end else begin
               w_shift = w_sck_rise;
            end
         end
         ST_LATCH: w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sr    <= '0;
         r_count <= '0;
         r_dout  <= 1'b0;
      end else begin
         if (w_shift) r_sr <= {r_sr[FRAME_W-2:0], w_mosi_q};
         if (w_clear)
            r_count <= w_shift ? CNT_W'(1) : '0;
         else if (w_shift && !w_full)
            r_count <= r_count + CNT_W'(1);
         if (r_state == ST_SHIFT && w_sck_fall) r_dout <= r_sr[FRAME_W-1];
      end
   end

   logic [7:0] r_digit [8];
   logic [7:0] r_decode_mode;
   logic [3:0] r_intensity;
   logic [2:0] r_scan_limit;
   logic       r_shutdown_n;
   logic       r_display_test;
   logic       r_frame_valid;
   logic       r_frame_error;
   logic [3:0] r_frame_addr;
   logic [7:0] r_frame_data;

   // Register writes land on the same edge the FSM enters LATCH, so outputs
   // follow the synchronised cs rise by exactly one clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the digit array is reset because it drives outputs that must read 0 after reset.
         for (int i = 0; i < 8; i++) r_digit[i] <= '0;
         r_decode_mode  <= '0;
         r_intensity    <= '0;
         r_scan_limit   <= '0;
         r_shutdown_n   <= 1'b0;
         r_display_test <= 1'b0;
         r_frame_valid  <= 1'b0;
         r_frame_error  <= 1'b0;
         r_frame_addr   <= '0;
         r_frame_data   <= '0;
      end else begin
         r_frame_valid <= 1'b0;
         r_frame_error <= 1'b0;
         if (w_commit && !w_full) begin
            r_frame_error <= 1'b1;
         end else if (w_commit) begin
            r_frame_valid <= 1'b1;
            r_frame_addr  <= w_addr;
            r_frame_data  <= w_data;
            case (w_addr)
               NOOP: ;
               DIGIT0, DIGIT1, DIGIT2, DIGIT3,
               DIGIT4, DIGIT5, DIGIT6, DIGIT7: r_digit[w_digit_idx] <= w_data;
               DECODE_MODE:  r_decode_mode  <= w_data;
               INTENSITY:    r_intensity    <= w_data[3:0];
               SCAN_LIMIT:   r_scan_limit   <= w_data[2:0];
               SHUTDOWN:     r_shutdown_n   <= w_data[0];
               DISPLAY_TEST: r_display_test <= w_data[0];
               default: ;
            endcase
         end
      end
   end

   assign pixels       = {r_digit[0], r_digit[1], r_digit[2], r_digit[3],
                          r_digit[4], r_digit[5], r_digit[6], r_digit[7]};
   assign decode_mode  = r_decode_mode;
   assign intensity    = r_intensity;
   assign scan_limit   = r_scan_limit;
   assign shutdown_n   = r_shutdown_n;
   assign display_test = r_display_test;
   assign frame_valid  = r_frame_valid;
   assign frame_error  = r_frame_error;
   assign frame_addr   = r_frame_addr;
   assign frame_data   = r_frame_data;
   assign dout         = r_dout;

endmodule
